sipo_deserializer: RTL
======================

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the number of serial bits per parallel word (legal range 2..64).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in parallel_out[DATA_WIDTH-1]; 0 = first bit lands in parallel_out[0].
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port serial_in, input, 1 bit: serial data bit.
REQ-006 The block SHALL have port serial_valid, input, 1 bit: serial_in is sampled on this edge when high.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous frame restart.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-009 The block SHALL have port parallel_out, output, DATA_WIDTH bits: assembled word from the holding register.
REQ-010 The block SHALL have port out_valid, output, 1 bit: parallel_out holds an unconsumed word.
REQ-011 The block SHALL have port bit_count, output, $clog2(DATA_WIDTH) bits: number of bits collected in the current partial word.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a completed word was dropped.

Function
REQ-013 On each rising edge with serial_valid=1 and clear=0, the block SHALL shift serial_in into the internal shift register in the configured bit order and increment bit_count.
REQ-014 The block SHALL leave the shift register and bit_count unchanged on edges with serial_valid=0.
REQ-015 When the edge samples the DATA_WIDTH-th bit, the block SHALL wrap bit_count to 0 on that same edge.
REQ-016 On that same edge, the block SHALL mark the completed word (all DATA_WIDTH bits, including the bit just sampled) for transfer to the holding register.
REQ-017 The block SHALL load the completed word into parallel_out and set out_valid=1 on the edge of the last bit (latency 1 cycle) if out_valid=0, or if out_valid=1 and out_ready=1 on that edge.
REQ-018 If a word completes while out_valid=1 and out_ready=0, the block SHALL discard the new word, keep parallel_out unchanged, and set overrun=1.
REQ-019 The block SHALL clear out_valid on an edge where out_valid=1, out_ready=1, and no word completes on that edge.
REQ-020 The block SHALL keep parallel_out stable whenever out_valid=1 and out_ready=0.
REQ-021 The block SHALL ignore out_ready while out_valid=0.
REQ-022 When clear=1, the block SHALL set bit_count to 0, zero the shift register, and set overrun to 0 on the next edge.
REQ-023 When clear=1 and serial_valid=1 on the same edge, clear SHALL take priority and the serial bit SHALL be discarded.
REQ-024 Clear SHALL NOT alter out_valid or parallel_out, and a pending word SHALL still be consumable via out_ready.
REQ-025 Overrun SHALL stay set until reset or clear, and a second overrun SHALL have no additional effect.
REQ-026 The block SHALL contain a 2-state FSM per word: COLLECT (bit_count < DATA_WIDTH-1) and LAST (the next valid bit completes the word), with state derived from bit_count.

Reset
REQ-027 While reset=1, independent of clk, the block SHALL set parallel_out=0, out_valid=0, bit_count=0, overrun=0, and zero the shift register.
REQ-028 Reset asserted mid-word SHALL discard the partial word.
REQ-029 After reset deasserts, the first bit sampled SHALL be treated as bit 0 of a new word.

Verification (bench DATA_WIDTH=8)
REQ-030 MSB_FIRST=1, serial_valid held high, bits 1,0,1,0,0,1,0,1 -> out_valid rises the cycle after the 8th edge with parallel_out=8'hA5, and bit_count shows 0 after that edge.
REQ-031 MSB_FIRST=0, same bit stream -> parallel_out=8'hA5 read LSB-first, i.e. 8'hA5 for the sequence 1,0,1,0,0,1,0,1 starting at bit 0.
REQ-032 serial_valid gapped (bits interleaved with random idle cycles), word 8'h3C -> parallel_out=8'h3C, and bit_count holds its value during the gaps.
REQ-033 out_ready=0 with two words 8'h11 then 8'h22 sent back-to-back -> parallel_out stays 8'h11 and overrun=1; raising out_ready for one cycle then drops out_valid.
REQ-034 out_ready=1 on the exact edge the next word completes -> no drop, parallel_out updates to the new word, out_valid stays 1, overrun=0.
REQ-035 Reset pulsed (asynchronously, between clock edges) after 5 bits, followed by a full 8'hF0 -> outputs read 0 immediately on reset, and the next word reads 8'hF0; separately, clear with serial_valid=1 after 3 bits -> bit_count=0 and overrun=0.

Source files
------------

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: collects serial bits into DATA_WIDTH-bit words and hands
// each finished word to a consumer through a one-entry holding register with a
// valid/ready handshake. A word that finishes while the holding register is
// still occupied and not being read is dropped, and the sticky overrun flag is
// raised.
module sipo_deserializer #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serial_in,
  input  logic                          serial_valid,
  input  logic                          clear,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         parallel_out,
  output logic                          out_valid,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_count,
  output logic                          overrun
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

  // COLLECT while more than one bit is still missing; LAST when the next
  // sampled bit finishes the word. The state is a decode of the bit counter,
  // so the counter register doubles as the state register.
  typedef enum logic {
    COLLECT = 1'b0,
    LAST    = 1'b1
  } state_e;

  state_e                state;
  logic [DATA_WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [DATA_WIDTH-1:0] holdReg_q, holdReg_d;
  logic [DATA_WIDTH-1:0] shiftedWord;
  logic [CW-1:0]         bitCount_q, bitCount_d;
  logic                  outValid_q, outValid_d;
  logic                  overrun_q, overrun_d;
  logic                  sampleBit;
  logic                  wordDone;
  logic                  loadWord;

  // State register: every storage element; reset clears the partial word too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shiftReg_q <= '0;
      holdReg_q  <= '0;
      bitCount_q <= '0;
      outValid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      shiftReg_q <= shiftReg_d;
      holdReg_q  <= holdReg_d;
      bitCount_q <= bitCount_d;
      outValid_q <= outValid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state logic: clear beats a simultaneous serial bit, and a finished
  // word goes to the holding register only if that register is free this edge.
  always_comb begin
    shiftReg_d = shiftReg_q;
    holdReg_d  = holdReg_q;
    bitCount_d = bitCount_q;
    outValid_d = outValid_q;
    overrun_d  = overrun_q;

    state     = (bitCount_q == LAST_COUNT) ? LAST : COLLECT;
    sampleBit = serial_valid && !clear;
    wordDone  = sampleBit && (state == LAST);
    loadWord  = wordDone && (!outValid_q || out_ready);

    if (MSB_FIRST) begin
      shiftedWord = {shiftReg_q[DATA_WIDTH-2:0], serial_in};
    end else begin
      shiftedWord = {serial_in, shiftReg_q[DATA_WIDTH-1:1]};
    end

    if (clear) begin
      shiftReg_d = '0;
      bitCount_d = '0;
      overrun_d  = 1'b0;
    end else if (sampleBit) begin
      shiftReg_d = shiftedWord;
      bitCount_d = wordDone ? '0 : bitCount_q + CW'(1);
    end

    if (loadWord) begin
      holdReg_d  = shiftedWord;
      outValid_d = 1'b1;
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end

    if (wordDone && !loadWord) begin
      overrun_d = 1'b1;
    end
  end

  // Output logic: all outputs come straight from registers.
  always_comb begin
    parallel_out = holdReg_q;
    out_valid    = outValid_q;
    bit_count    = bitCount_q;
    overrun      = overrun_q;
  end

endmodule
